// File: rtl/prime_det_pkg.sv
// prime_det_pkg: shared prime lookup constants and helper for the 3-bit prime detector
package prime_det_pkg;
    // Bit i is set iff i is prime (2, 3, 5, 7).
    localparam logic [7:0] PRIME_MASK = 8'b1010_1100;

    function automatic logic is_prime3(input logic [2:0] n);
        return PRIME_MASK[n];
    endfunction
endpackage

// File: rtl/prime_det_lut3.sv
// prime_lut3: combinational 3-bit prime lookup
//   n [2:0] in  : value to test
//   p       out : 1 when n is 2, 3, 5 or 7
module prime_lut3
    import prime_det_pkg::*;
(
    input  logic [2:0] n,
    output logic       p
);
    assign p = is_prime3(n);
endmodule

// File: rtl/prime_det.sv
// prime_det: 3-bit prime detector with registered flag, registered value and saturating hit counter
//   clk, rst_n      : rising-edge clock, async active-low reset
//   A, B, C         : N = {A,B,C}, A is the MSB
//   en              : sample enable for the clocked path
//   clr             : synchronous clear of the counter (wins over en for the counter)
//   F               : combinational prime flag, independent of clk/rst_n
//   F_q, val_q      : F and N captured on enabled edges
//   prime_cnt       : enabled cycles with F=1, saturating at all-ones
//   cnt_sat         : high while prime_cnt is all-ones
module prime_det
    import prime_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             en,
    input  logic             clr,
    output logic             F,
    output logic             F_q,
    output logic [2:0]       val_q,
    output logic [CNT_W-1:0] prime_cnt,
    output logic             cnt_sat
);
    logic [2:0]       n;
    logic             f_d, f_q;
    logic [2:0]       val_d;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign n = {A, B, C};

    prime_lut3 u_lut (
        .n (n),
        .p (F)
    );

    always_comb begin
        f_d   = en ? F : f_q;
        val_d = en ? n : val_q;
        cnt_d = clr                   ? '0 :
                (en && F && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q   <= 1'b0;
            val_q <= 3'b000;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign F_q       = f_q;
    assign prime_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;
endmodule

// File: tb/tb_prime_det.sv
// tb_prime_det: directed self-checking bench for prime_det
module tb_prime_det;
    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0;
    logic       en = 1'b0, clr = 1'b0, en2 = 1'b0, clr2 = 1'b0;
    logic       F, F_q, F2, F_q2, cnt_sat, cnt_sat2;
    logic [2:0] val_q, val_q2;
    logic [7:0] prime_cnt;
    logic [1:0] prime_cnt2;
    int         checks = 0;
    int         errors = 0;

    always #5 if (clk_run) clk = ~clk;

    prime_det #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .en(en), .clr(clr),
        .F(F), .F_q(F_q), .val_q(val_q), .prime_cnt(prime_cnt), .cnt_sat(cnt_sat)
    );

    prime_det #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .en(en2), .clr(clr2),
        .F(F2), .F_q(F_q2), .val_q(val_q2), .prime_cnt(prime_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_n(input int v);
        {A, B, C} = 3'(v);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (F_q !== 1'b0) begin errors++; $display("FAIL rst_fq got %b want 0", F_q); end
        checks++; if (val_q !== 3'b000) begin errors++; $display("FAIL rst_val got %b want 000", val_q); end
        checks++; if (prime_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", prime_cnt); end
        checks++; if (cnt_sat !== 1'b0) begin errors++; $display("FAIL rst_sat got %b want 0", cnt_sat); end
        checks++; if (prime_cnt2 !== 2'd0) begin errors++; $display("FAIL rst_cnt2 got %0d want 0", prime_cnt2); end
    endtask

    task automatic test_comb();
        logic [7:0] exp_f;
        exp_f = 8'b1010_1100;
        for (int i = 0; i < 8; i++) begin
            set_n(i);
            #10;
            checks++;
            if (F !== exp_f[i]) begin errors++; $display("FAIL comb_n%0d got %b want %b", i, F, exp_f[i]); end
        end
    endtask

    task automatic test_registered();
        en = 1'b1; set_n(5);
        tick();
        checks++; if (F_q !== 1'b1 || val_q !== 3'b101) begin errors++; $display("FAIL reg_n5 got F_q=%b val=%b want 1 101", F_q, val_q); end
        set_n(6);
        tick();
        checks++; if (F_q !== 1'b0 || val_q !== 3'b110) begin errors++; $display("FAIL reg_n6 got F_q=%b val=%b want 0 110", F_q, val_q); end
    endtask

    task automatic test_counter();
        int seq [4] = '{2, 4, 7, 3};
        int exp [4] = '{1, 1, 2, 3};
        clr = 1'b1; en = 1'b0;
        tick();
        clr = 1'b0;
        checks++; if (prime_cnt !== 8'd0) begin errors++; $display("FAIL cnt_clr got %0d want 0", prime_cnt); end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_n(seq[i]);
            tick();
            checks++;
            if (prime_cnt !== 8'(exp[i])) begin errors++; $display("FAIL cnt_n%0d got %0d want %0d", seq[i], prime_cnt, exp[i]); end
        end
        en = 1'b0; set_n(5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (prime_cnt !== 8'd3 || val_q !== 3'b011 || F_q !== 1'b1) begin
                errors++; $display("FAIL cnt_hold%0d got cnt=%0d val=%b F_q=%b want 3 011 1", i, prime_cnt, val_q, F_q);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_c [5] = '{1, 2, 3, 3, 3};
        logic [4:0] exp_s;
        exp_s = 5'b11100;
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0; en2 = 1'b1; set_n(7);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (prime_cnt2 !== 2'(exp_c[i]) || cnt_sat2 !== exp_s[i]) begin
                errors++; $display("FAIL sat_edge%0d got cnt=%0d sat=%b want %0d %b", i + 1, prime_cnt2, cnt_sat2, exp_c[i], exp_s[i]);
            end
        end
        en2 = 1'b0;
    endtask

    task automatic test_clear();
        en = 1'b1; clr = 1'b1; en2 = 1'b1; clr2 = 1'b1; set_n(3);
        tick();
        clr = 1'b0; clr2 = 1'b0; en2 = 1'b0; en = 1'b0;
        checks++; if (prime_cnt !== 8'd0 || cnt_sat !== 1'b0) begin errors++; $display("FAIL clr_cnt got %0d sat=%b want 0 0", prime_cnt, cnt_sat); end
        checks++; if (F_q !== 1'b1 || val_q !== 3'b011) begin errors++; $display("FAIL clr_reg got F_q=%b val=%b want 1 011", F_q, val_q); end
        checks++; if (prime_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0) begin errors++; $display("FAIL clr_sat2 got %0d sat=%b want 0 0", prime_cnt2, cnt_sat2); end
    endtask

    task automatic test_async_reset();
        en = 1'b1; set_n(2);
        tick();
        set_n(3);
        tick();
        checks++; if (prime_cnt !== 8'd2 || F_q !== 1'b1) begin errors++; $display("FAIL ar_pre got cnt=%0d F_q=%b want 2 1", prime_cnt, F_q); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (F_q !== 1'b0 || val_q !== 3'b000 || prime_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
            errors++; $display("FAIL ar_now got F_q=%b val=%b cnt=%0d sat=%b want 0 000 0 0", F_q, val_q, prime_cnt, cnt_sat);
        end
        set_n(5); #1;
        checks++; if (F !== 1'b1) begin errors++; $display("FAIL ar_f5 got %b want 1", F); end
        set_n(4); #1;
        checks++; if (F !== 1'b0) begin errors++; $display("FAIL ar_f4 got %b want 0", F); end
        tick();
        checks++; if (prime_cnt !== 8'd0 || val_q !== 3'b000) begin errors++; $display("FAIL ar_hold got cnt=%0d val=%b want 0 000", prime_cnt, val_q); end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; set_n(2);
        tick();
        checks++; if (prime_cnt !== 8'd1 || val_q !== 3'b010 || F_q !== 1'b1) begin
            errors++; $display("FAIL ar_resume got cnt=%0d val=%b F_q=%b want 1 010 1", prime_cnt, val_q, F_q);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb();
        rst_n = 1'b1;
        #3 clk_run = 1'b1;
        test_registered();
        test_counter();
        test_saturation();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
